// File: rtl/seq_divider_if.sv
// Request/response bundle for the sequential divider: operands in, quotient/remainder out.
// Handshake: a request is taken on a clock edge where start=1 and the divider is idle (busy=0);
// results are valid on the single cycle where done=1 and are held until the next done.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               sign;
  logic [WIDTH-1:0]   X;
  logic [WIDTH-1:0]   Y;
  logic               busy;
  logic               done;
  logic               div_by_zero;
  logic [WIDTH-1:0]   Q;
  logic [WIDTH-1:0]   R;
  logic [2*WIDTH-1:0] Z;

  modport master (
    output start, sign, X, Y,
    input  busy, done, div_by_zero, Q, R, Z
  );

  modport slave (
    input  start, sign, X, Y,
    output busy, done, div_by_zero, Q, R, Z
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock, signed (DIV) or unsigned (DIVU).
// Quotient goes to LO (Q), remainder to HI (R); Z = {R, Q} matches the multiplier product layout.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  seq_divider_if.slave      div_if,
  output logic [1:0]        state_o
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIX    = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_q;
  logic             xneg_q, yneg_q, ydz_q;
  logic [WIDTH-1:0] xraw_q, ymag_q, quot_q, rem_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] q_q, r_q;

  logic             xneg_d, yneg_d;
  logic [WIDTH-1:0] xmag_d, ymag_d, q_fix_d, r_fix_d;
  logic [WIDTH:0]   shift_rem_d, trial_d;

  always_comb begin
    xneg_d      = div_if.sign & div_if.X[WIDTH-1];
    yneg_d      = div_if.sign & div_if.Y[WIDTH-1];
    xmag_d      = xneg_d ? -div_if.X : div_if.X;
    ymag_d      = yneg_d ? -div_if.Y : div_if.Y;
    shift_rem_d = {rem_q, quot_q[WIDTH-1]};
    trial_d     = shift_rem_d - {1'b0, ymag_q};
    q_fix_d     = (xneg_q ^ yneg_q) ? -quot_q : quot_q;
    r_fix_d     = xneg_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      xneg_q  <= 1'b0;
      yneg_q  <= 1'b0;
      ydz_q   <= 1'b0;
      xraw_q  <= '0;
      ymag_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (div_if.start) begin
            xneg_q  <= xneg_d;
            yneg_q  <= yneg_d;
            ydz_q   <= (div_if.Y == '0);
            xraw_q  <= div_if.X;
            ymag_q  <= ymag_d;
            quot_q  <= xmag_d;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (div_if.Y == '0) ? FIX : DIVIDE;
          end
        end
        DIVIDE: begin
          // A negative trial means the shifted remainder was below |Y|, so it still fits WIDTH bits.
          if (!trial_d[WIDTH]) begin
            rem_q  <= trial_d[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q  <= shift_rem_d[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          if (ydz_q) begin
            q_q   <= '1;
            r_q   <= xraw_q;
            dbz_q <= 1'b1;
          end else begin
            q_q   <= q_fix_d;
            r_q   <= r_fix_d;
            dbz_q <= 1'b0;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div_if.busy        = busy_q;
  assign div_if.done        = done_q;
  assign div_if.div_by_zero = dbz_q;
  assign div_if.Q           = q_q;
  assign div_if.R           = r_q;
  assign div_if.Z           = {r_q, q_q};
  assign state_o            = state_q;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed operations checked against an arithmetic reference model
// with predicted done cycles, plus literal expectations for the listed cases.
module tb_seq_divider;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] state_dbg;
  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  // Expected {div_by_zero, R, Q} and the cycle on which done must be seen.
  logic [2*W:0] exp_q[$];
  int           due_q[$];

  seq_divider_if #(.WIDTH(W)) dif();

  seq_divider #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .div_if  (dif),
    .state_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [2*W:0] model(bit s, logic [W-1:0] x, logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [W-1:0] uq, ur;
    if (y == '0) return {1'b1, x, {W{1'b1}}};
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      return {1'b0, r[W-1:0], q[W-1:0]};
    end
    uq = x / y;
    ur = x % y;
    return {1'b0, ur, uq};
  endfunction

  task automatic check(string name, logic [2*W:0] act, logic [2*W:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(string name);
    total_cnt++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_exp(bit s, logic [W-1:0] x, logic [W-1:0] y, output int acc);
    acc = cyc;
    exp_q.push_back(model(s, x, y));
    due_q.push_back(cyc + ((y == '0) ? 1 : W + 1));
  endtask

  task automatic issue(bit s, logic [W-1:0] x, logic [W-1:0] y, output int acc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (dif.busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) fail_now("idle_wait");
    dif.start = 1'b1;
    dif.sign  = s;
    dif.X     = x;
    dif.Y     = y;
    @(posedge clk);
    #1;
    push_exp(s, x, y, acc);
    dif.start = 1'b0;
    dif.X     = $urandom;
    dif.Y     = $urandom;
    dif.sign  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int acc, output int lat);
    int n;
    @(negedge clk);
    n = 1;
    while (!dif.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!dif.done) fail_now("done_timeout");
    lat = cyc - acc;
  endtask

  task automatic run(string nm, bit s, logic [W-1:0] x, logic [W-1:0] y,
                     logic [W-1:0] eq, logic [W-1:0] er, bit ed, int el);
    int acc, lat;
    issue(s, x, y, acc);
    wait_done(acc, lat);
    check({nm, "_q"},   dif.Q, eq);
    check({nm, "_r"},   dif.R, er);
    check({nm, "_dbz"}, dif.div_by_zero, ed);
    check({nm, "_lat"}, lat, el);
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() > 0 && due_q[0] == cyc) begin
        logic [2*W:0] e;
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        check("sb_done",  dif.done, 1);
        check("sb_busy",  dif.busy, 0);
        check("sb_z",     dif.Z, e[2*W-1:0]);
        check("sb_dbz",   dif.div_by_zero, e[2*W]);
      end else begin
        check("sb_no_done", dif.done, 0);
        check("sb_busy",    dif.busy, exp_q.size() > 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc1, acc2, lat;
    dif.start = 1'b0;
    dif.sign  = 1'b0;
    dif.X     = '0;
    dif.Y     = '0;

    // Hand-computed pins on the model itself.
    check("pin_model_u", model(0, 32'd100, 32'd7), {1'b0, 32'd2, 32'd14});
    check("pin_model_s", model(1, 32'hFFFFFFF9, 32'hFFFFFFFE), {1'b0, 32'hFFFFFFFF, 32'd3});
    check("pin_model_ovf", model(1, 32'h80000000, 32'hFFFFFFFF), {1'b0, 32'd0, 32'h80000000});

    repeat (2) @(negedge clk);
    check("rst_busy",  dif.busy, 0);
    check("rst_done",  dif.done, 0);
    check("rst_dbz",   dif.div_by_zero, 0);
    check("rst_z",     dif.Z, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b0;

    run("u_100_7", 0, 32'd100, 32'd7, 32'd14, 32'd2, 0, W + 1);
    check("z_100_7", dif.Z, 64'h00000002_0000000E);
    run("s_m7_2",  1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 0, W + 1);
    run("s_7_m2",  1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        0, W + 1);
    run("s_m7_m2", 1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 0, W + 1);
    run("s_ovf",   1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        0, W + 1);
    run("u_max_1", 0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        0, W + 1);
    run("u_5_9",   0, 32'd5,        32'd9,        32'd0,        32'd5,        0, W + 1);
    run("u_m7_2",  0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1,        0, W + 1);
    run("dz_u",    0, 32'd1234,     32'd0,        32'hFFFFFFFF, 32'd1234,     1, 1);
    run("dz_s",    1, 32'd1234,     32'd0,        32'hFFFFFFFF, 32'd1234,     1, 1);
    run("u_10_3",  0, 32'd10,       32'd3,        32'd3,        32'd1,        0, W + 1);

    // start pulsed while busy must be ignored.
    issue(0, 32'd100, 32'd7, acc1);
    repeat (5) @(negedge clk);
    dif.start = 1'b1; dif.X = 32'd1; dif.Y = 32'd1;
    @(negedge clk);
    dif.start = 1'b0;
    wait_done(acc1, lat);
    check("mid_q", dif.Q, 32'd14);
    check("mid_r", dif.R, 32'd2);
    check("mid_lat", lat, W + 1);
    repeat (5) @(negedge clk);

    // start held high through done: second op accepted on the edge after done.
    dif.start = 1'b1; dif.sign = 1'b0; dif.X = 32'd20; dif.Y = 32'd6;
    @(posedge clk);
    #1;
    push_exp(0, 32'd20, 32'd6, acc1);
    dif.X = 32'd10; dif.Y = 32'd3;
    wait_done(acc1, lat);
    check("held1_q", dif.Q, 32'd3);
    check("held1_r", dif.R, 32'd2);
    check("held1_lat", lat, W + 1);
    @(posedge clk);
    #1;
    push_exp(0, 32'd10, 32'd3, acc2);
    dif.start = 1'b0;
    check("held_spacing", acc2 - acc1, W + 2);
    wait_done(acc2, lat);
    check("held2_q", dif.Q, 32'd3);
    check("held2_r", dif.R, 32'd1);
    check("held2_lat", lat, W + 1);

    // Asynchronous reset mid-operation.
    issue(0, 32'd100, 32'd7, acc1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_busy", dif.busy, 0);
    check("arst_done", dif.done, 0);
    check("arst_q",    dif.Q, 0);
    check("arst_r",    dif.R, 0);
    check("arst_z",    dif.Z, 0);
    exp_q.delete();
    due_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    run("u_9_4", 0, 32'd9, 32'd4, 32'd2, 32'd1, 0, W + 1);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
